collisions_scan: RTL and testbench

//  Multi-projectile successor to the single-bullet invader collision checker. Once per frame it

---
 rtl/invaders_pkg.sv | 10 +
 rtl/aabb_overlap.sv | 21 ++
 rtl/collisions_scan.sv | 244 ++++++++++++++++++++++++
 tb/tb_collisions_scan.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared types and constants for the invader collision scanner.
package invaders_pkg;

  typedef logic [11:0] coord_t;

  typedef enum logic [1:0] {IDLE, SCAN, BOTTOM} scan_state_t;

  localparam int unsigned ROW_POINTS = 10;

endpackage

// File: rtl/aabb_overlap.sv
// Inclusive axis-aligned rectangle overlap test on 13-bit widened coordinates.
module aabb_overlap #(
  parameter int unsigned A_W = 16,
  parameter int unsigned A_H = 32,
  parameter int unsigned B_W = 64,
  parameter int unsigned B_H = 32
) (
  input  logic [12:0] a_x,
  input  logic [12:0] a_y,
  input  logic [12:0] b_x,
  input  logic [12:0] b_y,
  output logic        hit
);

  // Touching edges count as overlap.
  always_comb begin
    hit = (a_x <= b_x + 13'(B_W)) && (a_x + 13'(A_W) >= b_x) &&
          (a_y <= b_y + 13'(B_H)) && (a_y + 13'(A_H) >= b_y);
  end

endmodule

// File: rtl/collisions_scan.sv
// Per-frame projectile x invader grid scanner, one cell per clock.
// Optional COLLISIONS_SCORE_EN adds a saturating score output.
module collisions_scan
  import invaders_pkg::*;
#(
  parameter int unsigned NUM_PROJ          = 2,
  parameter int unsigned NUM_INVADERS      = 10,
  parameter int unsigned NUM_ROWS          = 3,
  parameter int unsigned OFFSET            = 100,
  parameter int unsigned INVADER_WIDTH     = 64,
  parameter int unsigned INVADER_HEIGHT    = 32,
  parameter int unsigned PROJECTILE_WIDTH  = 16,
  parameter int unsigned PROJECTILE_HEIGHT = 32,
  parameter int unsigned PLAYER_LINE       = 568,
  localparam int unsigned PW = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1,
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned CW = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_start,
  input  logic                                 wave_reset,
  input  logic [NUM_PROJ-1:0]                  proj_active,
  input  logic [NUM_PROJ-1:0][11:0]            proj_xpos,
  input  logic [NUM_PROJ-1:0][11:0]            proj_ypos,
  input  logic [NUM_INVADERS-1:0][11:0]        inv_xpos,
  input  logic [9:0]                           enemy_ypos,
  output logic [NUM_ROWS-1:0][NUM_INVADERS-1:0] alive,
  output logic [NUM_PROJ-1:0]                  proj_hit,
  output logic                                 kill_valid,
  output logic [RW-1:0]                        kill_row,
  output logic [CW-1:0]                        kill_col,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overrun,
  output logic                                 player_hit,
  output logic                                 all_dead
`ifdef COLLISIONS_SCORE_EN
  ,
  output logic [15:0]                          score
`endif
);

  scan_state_t state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [NUM_ROWS-1:0][NUM_INVADERS-1:0] alive_q, alive_d;
  logic [NUM_PROJ-1:0] proj_hit_q, proj_hit_d;
  logic          kill_valid_q, kill_valid_d;
  logic [RW-1:0] kill_row_q, kill_row_d;
  logic [CW-1:0] kill_col_q, kill_col_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          player_hit_q, player_hit_d;
  logic          latch_en;

  logic [NUM_PROJ-1:0]           proj_act_q;
  coord_t [NUM_PROJ-1:0]         proj_x_q, proj_y_q;
  coord_t [NUM_INVADERS-1:0]     inv_x_q;
  logic [9:0]                    ey_q;

  logic [12:0] cell_y;
  logic        cell_overlap;
  logic        cell_hit;
  logic        any_live;
  logic [RW-1:0] low_row;
  logic [15:0] bottom_y;

  always_comb cell_y = 13'(ey_q) + 13'(r_q) * 13'(OFFSET);

  aabb_overlap #(
    .A_W (PROJECTILE_WIDTH),
    .A_H (PROJECTILE_HEIGHT),
    .B_W (INVADER_WIDTH),
    .B_H (INVADER_HEIGHT)
  ) u_overlap (
    .a_x (13'(proj_x_q[p_q])),
    .a_y (13'(proj_y_q[p_q])),
    .b_x (13'(inv_x_q[c_q])),
    .b_y (cell_y),
    .hit (cell_overlap)
  );

  // A projectile that already scored this frame is spent for the rest of the scan.
  always_comb begin
    cell_hit = cell_overlap && alive_q[r_q][c_q] && proj_act_q[p_q] && !proj_hit_q[p_q];
  end

  // Lowest live row on screen is the highest row index with any survivor.
  always_comb begin
    any_live = 1'b0;
    low_row  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (|alive_q[r]) begin
        any_live = 1'b1;
        low_row  = RW'(r);
      end
    end
    bottom_y = 16'(ey_q) + 16'(low_row) * 16'(OFFSET) + 16'(INVADER_HEIGHT);
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    r_d          = r_q;
    c_d          = c_q;
    alive_d      = alive_q;
    proj_hit_d   = proj_hit_q;
    kill_valid_d = 1'b0;
    kill_row_d   = kill_row_q;
    kill_col_d   = kill_col_q;
    done_d       = 1'b0;
    overrun_d    = 1'b0;
    player_hit_d = player_hit_q;
    latch_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = SCAN;
          latch_en   = 1'b1;
          proj_hit_d = '0;
          p_d        = '0;
          r_d        = RW'(NUM_ROWS - 1);
          c_d        = '0;
        end
      end
      SCAN: begin
        overrun_d = frame_start;
        if (cell_hit) begin
          alive_d[r_q][c_q] = 1'b0;
          proj_hit_d[p_q]   = 1'b1;
          kill_valid_d      = 1'b1;
          kill_row_d        = r_q;
          kill_col_d        = c_q;
        end
        if (c_q == CW'(NUM_INVADERS - 1)) begin
          c_d = '0;
          if (r_q == '0) begin
            r_d = RW'(NUM_ROWS - 1);
            if (p_q == PW'(NUM_PROJ - 1)) state_d = BOTTOM;
            else p_d = p_q + 1'b1;
          end else begin
            r_d = r_q - 1'b1;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      BOTTOM: begin
        overrun_d = frame_start;
        if (any_live && (bottom_y >= 16'(PLAYER_LINE))) player_hit_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wave_reset) begin
      state_d      = IDLE;
      alive_d      = '1;
      proj_hit_d   = '0;
      kill_valid_d = 1'b0;
      done_d       = 1'b0;
      overrun_d    = 1'b0;
      player_hit_d = 1'b0;
      latch_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      p_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      alive_q      <= '1;
      proj_hit_q   <= '0;
      kill_valid_q <= 1'b0;
      kill_row_q   <= '0;
      kill_col_q   <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      player_hit_q <= 1'b0;
      proj_act_q   <= '0;
      proj_x_q     <= '0;
      proj_y_q     <= '0;
      inv_x_q      <= '0;
      ey_q         <= '0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      r_q          <= r_d;
      c_q          <= c_d;
      alive_q      <= alive_d;
      proj_hit_q   <= proj_hit_d;
      kill_valid_q <= kill_valid_d;
      kill_row_q   <= kill_row_d;
      kill_col_q   <= kill_col_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      player_hit_q <= player_hit_d;
      if (latch_en) begin
        proj_act_q <= proj_active;
        proj_x_q   <= proj_xpos;
        proj_y_q   <= proj_ypos;
        inv_x_q    <= inv_xpos;
        ey_q       <= enemy_ypos;
      end
    end
  end

`ifdef COLLISIONS_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  always_comb score_sum = {1'b0, score_q} + 17'((32'(kill_row_q) + 32'd1) * ROW_POINTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else if (wave_reset) begin
      score_q <= '0;
    end else if (kill_valid_q) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_q;
`endif

  assign alive      = alive_q;
  assign proj_hit   = proj_hit_q;
  assign kill_valid = kill_valid_q;
  assign kill_row   = kill_row_q;
  assign kill_col   = kill_col_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;
  assign player_hit = player_hit_q;
  assign all_dead   = ~|alive_q;

endmodule

// File: tb/tb_collisions_scan.sv
// Bench for collisions_scan: frame-level model plus directed scenarios.
module tb_collisions_scan;

  localparam int P = 2;
  localparam int R = 3;
  localparam int C = 10;
  localparam int CELLS = P * R * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic wave_reset = 1'b0;
  logic [P-1:0] proj_active = '0;
  logic [P-1:0][11:0] proj_xpos = '0;
  logic [P-1:0][11:0] proj_ypos = '0;
  logic [C-1:0][11:0] inv_xpos;
  logic [9:0] enemy_ypos = 10'd50;
  logic [R-1:0][C-1:0] alive;
  logic [P-1:0] proj_hit;
  logic kill_valid;
  logic [1:0] kill_row;
  logic [3:0] kill_col;
  logic busy, done, overrun, player_hit, all_dead;
`ifdef COLLISIONS_SCORE_EN
  logic [15:0] score;
`endif

  collisions_scan dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .wave_reset  (wave_reset),
    .proj_active (proj_active),
    .proj_xpos   (proj_xpos),
    .proj_ypos   (proj_ypos),
    .inv_xpos    (inv_xpos),
    .enemy_ypos  (enemy_ypos),
    .alive       (alive),
    .proj_hit    (proj_hit),
    .kill_valid  (kill_valid),
    .kill_row    (kill_row),
    .kill_col    (kill_col),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .player_hit  (player_hit),
    .all_dead    (all_dead)
`ifdef COLLISIONS_SCORE_EN
    ,
    .score       (score)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [R-1:0][C-1:0] m_alive = '1;
  logic [P-1:0] m_phit = '0;
  bit  m_player = 0;
  bit  running = 0;
  int  ofs = 0;
  bit  e_kill = 0, e_done = 0, e_over = 0;
  int  e_kr = 0, e_kc = 0;
  int  m_score = 0;
  bit  kv[64];
  int  kr[64], kc[64], kp[64];
  bit  f_player;

  function automatic bit ovl(int px, int py, int ix, int iy);
    return (px <= ix + 64) && (px + 16 >= ix) && (py <= iy + 32) && (py + 32 >= iy);
  endfunction

  // Resolve the whole frame at once: kill schedule and final player_hit decision.
  task automatic start_frame();
    logic [R-1:0][C-1:0] sim;
    int low;
    sim = m_alive;
    for (int i = 0; i < 64; i++) kv[i] = 0;
    for (int p = 0; p < P; p++) begin
      bit got = 0;
      if (!proj_active[p]) continue;
      for (int r = R - 1; r >= 0 && !got; r--) begin
        for (int c = 0; c < C && !got; c++) begin
          if (sim[r][c] && ovl(int'(proj_xpos[p]), int'(proj_ypos[p]), int'(inv_xpos[c]),
                               int'(enemy_ypos) + r * 100)) begin
            int k;
            k = p * R * C + (R - 1 - r) * C + c;
            sim[r][c] = 1'b0;
            kv[k + 1] = 1; kr[k + 1] = r; kc[k + 1] = c; kp[k + 1] = p;
            got = 1;
          end
        end
      end
    end
    low = -1;
    for (int r = 0; r < R; r++) if (sim[r] != '0) low = r;
    f_player = (low >= 0) && (int'(enemy_ypos) + low * 100 + 32 >= 568);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alive = '1; m_phit = '0; m_player = 0; running = 0; ofs = 0;
      e_kill = 0; e_done = 0; e_over = 0; m_score = 0;
    end else begin
      if (e_kill) begin
        m_score = m_score + (e_kr + 1) * 10;
        if (m_score > 65535) m_score = 65535;
      end
      e_kill = 0; e_done = 0; e_over = 0;
      if (wave_reset) begin
        m_alive = '1; m_phit = '0; m_player = 0; running = 0; m_score = 0;
      end else if (running) begin
        e_over = frame_start;
        ofs++;
        if (kv[ofs]) begin
          m_alive[kr[ofs]][kc[ofs]] = 1'b0;
          m_phit[kp[ofs]] = 1'b1;
          e_kill = 1; e_kr = kr[ofs]; e_kc = kc[ofs];
        end
        if (ofs == CELLS + 1) begin
          e_done = 1;
          running = 0;
          if (f_player) m_player = 1;
        end
      end else if (frame_start) begin
        start_frame();
        m_phit = '0;
        running = 1;
        ofs = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, running);
      chk("done", done, e_done);
      chk("overrun", overrun, e_over);
      chk("kill_valid", kill_valid, e_kill);
      if (e_kill) begin
        chk("kill_row", kill_row, e_kr);
        chk("kill_col", kill_col, e_kc);
      end
      chk("alive", alive, m_alive);
      chk("proj_hit", proj_hit, m_phit);
      chk("player_hit", player_hit, m_player);
      chk("all_dead", all_dead, m_alive == '0);
`ifdef COLLISIONS_SCORE_EN
      chk("score", score, m_score);
`endif
    end
  end

  // ---------------- stimulus ----------------
  int nkill, lrow, lcol;

  task automatic run_frame(output int de);
    de = -1;
    nkill = 0;
    frame_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (kill_valid) begin nkill++; lrow = int'(kill_row); lcol = int'(kill_col); end
      if (done) begin de = n + 1; break; end
      @(negedge clk);
    end
    if (de < 0) chk("frame_timeout", 0, 1);
  endtask

  task automatic pulse_wave_reset();
    wave_reset = 1'b1;
    @(negedge clk);
    wave_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_proj(input int p, input bit act, input int x, input int y);
    proj_active[p] = act;
    proj_xpos[p] = 12'(x);
    proj_ypos[p] = 12'(y);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int de, ndone, nover;
    for (int c = 0; c < C; c++) inv_xpos[c] = 12'(100 + 80 * c);

    // 1: reset values, empty frame timing
    @(negedge clk); @(negedge clk);
    chk("rst_alive", alive, 30'h3FFF_FFFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_phit", proj_hit, 0);
    chk("rst_player", player_hit, 0);
    chk("rst_kill", kill_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(de);
    chk("t1_done_edge", de, 62);
    chk("t1_alive", alive, 30'h3FFF_FFFF);

    // 2: exact corner touch on [2][4]
    set_proj(0, 1, 420 + 64, 50 + 200);
    set_proj(1, 0, 0, 0);
    run_frame(de);
    chk("t2_nkill", nkill, 1);
    chk("t2_row", lrow, 2);
    chk("t2_col", lcol, 4);
    chk("t2_phit", proj_hit, 2'b01);
    chk("t2_cell", alive[2][4], 0);

    // 3: both shots on [1][3], lower index wins
    set_proj(0, 1, 350, 160);
    set_proj(1, 1, 350, 160);
    run_frame(de);
    chk("t3_nkill", nkill, 1);
    chk("t3_row", lrow, 1);
    chk("t3_col", lcol, 3);
    chk("t3_phit", proj_hit, 2'b01);

    // 4: shot straddling [2][0] and [2][1]
    set_proj(0, 1, 164, 260);
    set_proj(1, 0, 0, 0);
    run_frame(de);
    chk("t4_nkill", nkill, 1);
    chk("t4_c0", alive[2][0], 0);
    chk("t4_c1", alive[2][1], 1);

    // 5: player line boundary and lowest-live-row selection
    pulse_wave_reset();
    set_proj(0, 0, 0, 0);
    enemy_ypos = 10'd336;
    run_frame(de);
    chk("t5_line568", player_hit, 1);
    pulse_wave_reset();
    enemy_ypos = 10'd335;
    for (int k = 0; k < 5; k++) begin
      set_proj(0, 1, 100 + 80 * (2 * k) + 24, 540);
      set_proj(1, 1, 100 + 80 * (2 * k + 1) + 24, 540);
      run_frame(de);
      chk("t5_nkill", nkill, 2);
    end
    chk("t5_row2_dead", alive[2], 0);
    chk("t5_no_player", player_hit, 0);
    set_proj(0, 0, 0, 0);
    set_proj(1, 0, 0, 0);
    enemy_ypos = 10'd435;
    run_frame(de);
    chk("t5_row1_567", player_hit, 0);
    enemy_ypos = 10'd436;
    run_frame(de);
    chk("t5_row1_568", player_hit, 1);

    // 6: overrun mid-scan, then wave_reset mid-scan
    pulse_wave_reset();
    enemy_ypos = 10'd50;
    set_proj(0, 1, 484, 250);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    ndone = 0; nover = 0;
    for (int n = 1; n < 90; n++) begin
      frame_start = (n == 20);
      @(negedge clk);
      if (done) ndone++;
      if (overrun) nover++;
    end
    frame_start = 1'b0;
    chk("t6_ndone", ndone, 1);
    chk("t6_nover", nover, 1);
`ifdef COLLISIONS_SCORE_EN
    chk("t6_score", score, 30);
`endif
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (29) @(negedge clk);
    chk("t6_busy_mid", busy, 1);
    wave_reset = 1'b1;
    @(negedge clk);
    wave_reset = 1'b0;
    chk("t6_wr_busy", busy, 0);
    chk("t6_wr_alive", alive, 30'h3FFF_FFFF);
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6_wr_nodone", ndone, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
